pwm_capture_array: RTL and testbench

Parametrised multi-channel PWM capture peripheral behind an Avalon-MM slave. It synchronises NUM_CH asynchronous PWM inputs and measures each channel's high time and period in prescaled clock ticks. It flags each channel as valid or stale through a per-channel timeout and records sticky timeout events. It sits on the system interconnect as the successor peripheral for RC/servo PWM decoding, adding a registered read path, a control register and staleness detection.

---
 rtl/pwm_capture_array.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_pwm_capture_array.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_array.sv
// pwm_capture_array
//
// Multi-channel PWM capture peripheral on an Avalon-MM slave. Each of the
// NUM_CH asynchronous inputs is synchronised, edge detected and measured in
// prescaled ticks: HIGH is the high time and PERIOD is the rising-to-rising
// time. A per-channel stale counter drops a channel's valid flag, clears its
// measurements and sets a sticky timeout bit when no rising edge arrives for
// TIMEOUT_TICKS ticks.
//
// Register map (word addresses):
//   0        STATUS  [31:24] NUM_CH, [23:16] CNT_W, [15:8] sticky (W1C), [7:0] valid
//   1        CTRL    bit0 enable (reset 1)
//   2+2i     HIGH_i
//   3+2i     PERIOD_i
//   others   read 0xFFFF_FFFF, writes ignored
//
// Ports:
//   clock_clk, reset_reset_n       clock, asynchronous active-low reset
//   avs_s0_*                       Avalon-MM slave, fixed read latency of 1,
//                                  waitrequest tied low
//   pwm_in[NUM_CH-1:0]             asynchronous PWM inputs, bit i = channel i
//
// Optional feature macro: PWM_CAPTURE_SNAPSHOT_EN
//   When defined, reading HIGH_i copies PERIOD_i into a per-channel shadow
//   and PERIOD_i reads return that shadow, making a HIGH-then-PERIOD read
//   pair coherent. When undefined, PERIOD_i reads return the live register.
//
// Bus handshake: a read accepted in cycle N (avs_s0_read high) returns data
// with avs_s0_readdatavalid high in cycle N+1; readdata holds until the next
// read. Writes take effect at the end of the accepting cycle. The slave never
// stalls, so every strobe is accepted in the cycle it is presented.

module pwm_capture_array #(
    parameter int NUM_CH        = 6,
    parameter int CNT_W         = 16,
    parameter int PRESCALE      = 50,
    parameter int TIMEOUT_TICKS = 50000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clock_clk,
    input  logic              reset_reset_n,
    input  logic [4:0]        avs_s0_address,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [31:0]       avs_s0_writedata,
    output logic [31:0]       avs_s0_readdata,
    output logic              avs_s0_readdatavalid,
    output logic              avs_s0_waitrequest,
    input  logic [NUM_CH-1:0] pwm_in
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int ST_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ST_W-1:0]  ST_MAX  = {ST_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                               enable_q, enable_d;
    logic [PS_W-1:0]                    ps_q, ps_d;
    logic                               tick;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
    logic [NUM_CH-1:0]                  prev_q, prev_d;
    logic [NUM_CH-1:0]                  in_s, rise, fall;
    logic [NUM_CH-1:0]                  armed_q, armed_d;
    logic [NUM_CH-1:0]                  valid_q, valid_d;
    logic [NUM_CH-1:0]                  sticky_q, sticky_d;
    logic [NUM_CH-1:0]                  stale_hit, timeout_ev;
    logic [CNT_W-1:0]                   period_cnt_q [NUM_CH];
    logic [CNT_W-1:0]                   period_cnt_d [NUM_CH];
    logic [CNT_W-1:0]                   high_cnt_q   [NUM_CH];
    logic [CNT_W-1:0]                   high_cnt_d   [NUM_CH];
    logic [ST_W-1:0]                    stale_cnt_q  [NUM_CH];
    logic [ST_W-1:0]                    stale_cnt_d  [NUM_CH];
    logic [CNT_W-1:0]                   high_reg_q   [NUM_CH];
    logic [CNT_W-1:0]                   high_reg_d   [NUM_CH];
    logic [CNT_W-1:0]                   period_reg_q [NUM_CH];
    logic [CNT_W-1:0]                   period_reg_d [NUM_CH];
`ifdef PWM_CAPTURE_SNAPSHOT_EN
    logic [CNT_W-1:0]                   shadow_q     [NUM_CH];
    logic [CNT_W-1:0]                   shadow_d     [NUM_CH];
`endif
    logic [31:0]                        readdata_q, readdata_d;
    logic                               rdv_q, rdv_d;
    logic [31:0]                        status;
    logic [31:0]                        rd_mux;
    logic                               unused_wdata;

    // Only bit 0 and the sticky field of writedata are ever consumed.
    assign unused_wdata = ^avs_s0_writedata;

    // Adds the current-cycle tick on top of a saturating counter. Counters
    // are cleared on the edge cycle, so the capture must include the tick of
    // the capturing cycle for a full N-tick interval to read back as N.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic b);
        return (b && (a != CNT_MAX)) ? a + CNT_W'(1) : a;
    endfunction

    // ------------------------------------------------------------------
    // Control register and prescaler
    // ------------------------------------------------------------------
    always_comb begin
        enable_d = enable_q;
        if (avs_s0_write && avs_s0_address == 5'd1)
            enable_d = avs_s0_writedata[0];
    end

    // With PRESCALE=1 the counter sits at 0 == PRESCALE-1, so tick is
    // high every enabled cycle without a special case.
    always_comb begin
        tick = 1'b0;
        ps_d = ps_q;
        if (!enable_q) begin
            ps_d = '0;
        end else if (ps_q == PS_W'(PRESCALE - 1)) begin
            tick = 1'b1;
            ps_d = '0;
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Synchroniser and edge detection
    // ------------------------------------------------------------------
    always_comb begin
        sync_d[0] = pwm_in;
        for (int s = 1; s < SYNC_STAGES; s++)
            sync_d[s] = sync_q[s-1];
    end

    assign in_s   = sync_q[SYNC_STAGES-1];
    assign prev_d = in_s;
    assign rise   = in_s & ~prev_q;
    assign fall   = ~in_s & prev_q;

    always_comb begin
        stale_hit = '0;
        for (int i = 0; i < NUM_CH; i++)
            stale_hit[i] = (stale_cnt_q[i] == ST_W'(TIMEOUT_TICKS));
    end

    // Only an armed channel can time out, which makes the event one-shot.
    // A rising edge in the same cycle wins over the timeout.
    assign timeout_ev = {NUM_CH{enable_q}} & armed_q & stale_hit & ~rise;

    // ------------------------------------------------------------------
    // Per-channel measurement
    // ------------------------------------------------------------------
    always_comb begin
        armed_d  = armed_q;
        valid_d  = valid_q;
        sticky_d = sticky_q;
        if (avs_s0_write && avs_s0_address == 5'd0)
            sticky_d = sticky_q & ~avs_s0_writedata[8 +: NUM_CH];

        for (int i = 0; i < NUM_CH; i++) begin
            period_cnt_d[i] = period_cnt_q[i];
            high_cnt_d[i]   = high_cnt_q[i];
            stale_cnt_d[i]  = stale_cnt_q[i];
            high_reg_d[i]   = high_reg_q[i];
            period_reg_d[i] = period_reg_q[i];
`ifdef PWM_CAPTURE_SNAPSHOT_EN
            shadow_d[i] = shadow_q[i];
            if (avs_s0_read && avs_s0_address == 5'(2 + 2*i))
                shadow_d[i] = period_reg_q[i];
`endif

            if (!enable_q) begin
                period_cnt_d[i] = '0;
                high_cnt_d[i]   = '0;
                stale_cnt_d[i]  = '0;
                high_reg_d[i]   = '0;
                period_reg_d[i] = '0;
                armed_d[i]      = 1'b0;
                valid_d[i]      = 1'b0;
`ifdef PWM_CAPTURE_SNAPSHOT_EN
                shadow_d[i]     = '0;
`endif
            end else begin
                if (tick) begin
                    period_cnt_d[i] = sat_add(period_cnt_q[i], 1'b1);
                    if (in_s[i])
                        high_cnt_d[i] = sat_add(high_cnt_q[i], 1'b1);
                    if (stale_cnt_q[i] != ST_MAX)
                        stale_cnt_d[i] = stale_cnt_q[i] + ST_W'(1);
                end

                if (fall[i] && armed_q[i])
                    high_reg_d[i] = sat_add(high_cnt_q[i], tick);

                if (rise[i]) begin
                    if (armed_q[i]) begin
                        period_reg_d[i] = sat_add(period_cnt_q[i], tick);
                        valid_d[i]      = 1'b1;
                    end
                    armed_d[i]      = 1'b1;
                    period_cnt_d[i] = '0;
                    high_cnt_d[i]   = '0;
                    stale_cnt_d[i]  = '0;
                end else if (timeout_ev[i]) begin
                    valid_d[i]      = 1'b0;
                    armed_d[i]      = 1'b0;
                    high_reg_d[i]   = '0;
                    period_reg_d[i] = '0;
                    sticky_d[i]     = 1'b1;  // set beats a same-cycle W1C
`ifdef PWM_CAPTURE_SNAPSHOT_EN
                    shadow_d[i]     = '0;
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: mux of pre-write values, registered once
    // ------------------------------------------------------------------
    always_comb begin
        status              = '0;
        status[31:24]       = 8'(NUM_CH);
        status[23:16]       = 8'(CNT_W);
        status[8 +: NUM_CH] = sticky_q;
        status[NUM_CH-1:0]  = valid_q;
    end

    always_comb begin
        rd_mux = 32'hFFFF_FFFF;
        if (avs_s0_address == 5'd0)
            rd_mux = status;
        else if (avs_s0_address == 5'd1)
            rd_mux = {31'd0, enable_q};
        for (int i = 0; i < NUM_CH; i++) begin
            if (avs_s0_address == 5'(2 + 2*i))
                rd_mux = 32'(high_reg_q[i]);
            if (avs_s0_address == 5'(3 + 2*i)) begin
`ifdef PWM_CAPTURE_SNAPSHOT_EN
                rd_mux = 32'(shadow_q[i]);
`else
                rd_mux = 32'(period_reg_q[i]);
`endif
            end
        end
    end

    always_comb begin
        readdata_d = avs_s0_read ? rd_mux : readdata_q;
        rdv_d      = avs_s0_read;
    end

    assign avs_s0_readdata      = readdata_q;
    assign avs_s0_readdatavalid = rdv_q;
    assign avs_s0_waitrequest   = 1'b0;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            enable_q   <= 1'b1;
            ps_q       <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            armed_q    <= '0;
            valid_q    <= '0;
            sticky_q   <= '0;
            readdata_q <= '0;
            rdv_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_cnt_q[i] <= '0;
                high_cnt_q[i]   <= '0;
                stale_cnt_q[i]  <= '0;
                high_reg_q[i]   <= '0;
                period_reg_q[i] <= '0;
`ifdef PWM_CAPTURE_SNAPSHOT_EN
                shadow_q[i]     <= '0;
`endif
            end
        end else begin
            enable_q   <= enable_d;
            ps_q       <= ps_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            armed_q    <= armed_d;
            valid_q    <= valid_d;
            sticky_q   <= sticky_d;
            readdata_q <= readdata_d;
            rdv_q      <= rdv_d;
            for (int i = 0; i < NUM_CH; i++) begin
                period_cnt_q[i] <= period_cnt_d[i];
                high_cnt_q[i]   <= high_cnt_d[i];
                stale_cnt_q[i]  <= stale_cnt_d[i];
                high_reg_q[i]   <= high_reg_d[i];
                period_reg_q[i] <= period_reg_d[i];
`ifdef PWM_CAPTURE_SNAPSHOT_EN
                shadow_q[i]     <= shadow_d[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture_array.sv
// Testbench for pwm_capture_array. Three instances share the bus inputs and
// PWM inputs: the main configuration (CNT_W=16, PRESCALE=1, TIMEOUT=1000),
// a narrow-counter instance (CNT_W=8, TIMEOUT=2000) and a prescaled instance
// (PRESCALE=4). Expected values come from a small channel model that records
// what each driven waveform should measure.

module tb_pwm_capture_array;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;
`ifdef PWM_CAPTURE_SNAPSHOT_EN
    localparam int SNAP_EXP = 100;
`else
    localparam int SNAP_EXP = 200;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic        ch0_pin = 1'b0;
    logic        ch1_pin = 1'b0;
    logic [1:0]  pwm;
    assign pwm = {ch1_pin, ch0_pin};

    logic [31:0] rdata_m, rdata_s, rdata_p;
    logic        rdv_m, rdv_s, rdv_p;
    logic        wait_m, wait_s, wait_p;

    pwm_capture_array #(.NUM_CH(2), .CNT_W(16), .PRESCALE(1), .TIMEOUT_TICKS(1000), .SYNC_STAGES(2)) dut (
        .clock_clk(clk), .reset_reset_n(rst_n), .avs_s0_address(addr), .avs_s0_read(rd),
        .avs_s0_write(wr), .avs_s0_writedata(wdata), .avs_s0_readdata(rdata_m),
        .avs_s0_readdatavalid(rdv_m), .avs_s0_waitrequest(wait_m), .pwm_in(pwm));

    pwm_capture_array #(.NUM_CH(2), .CNT_W(8), .PRESCALE(1), .TIMEOUT_TICKS(2000), .SYNC_STAGES(2)) dut_sat (
        .clock_clk(clk), .reset_reset_n(rst_n), .avs_s0_address(addr), .avs_s0_read(rd),
        .avs_s0_write(wr), .avs_s0_writedata(wdata), .avs_s0_readdata(rdata_s),
        .avs_s0_readdatavalid(rdv_s), .avs_s0_waitrequest(wait_s), .pwm_in(pwm));

    pwm_capture_array #(.NUM_CH(2), .CNT_W(16), .PRESCALE(4), .TIMEOUT_TICKS(1000), .SYNC_STAGES(2)) dut_ps (
        .clock_clk(clk), .reset_reset_n(rst_n), .avs_s0_address(addr), .avs_s0_read(rd),
        .avs_s0_write(wr), .avs_s0_writedata(wdata), .avs_s0_readdata(rdata_p),
        .avs_s0_readdatavalid(rdv_p), .avs_s0_waitrequest(wait_p), .pwm_in(pwm));

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int m_high   [NUM_CH];
    int m_period [NUM_CH];
    bit m_valid  [NUM_CH];
    bit m_sticky [NUM_CH];

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = {8'(NUM_CH), 8'(CNT_W), 16'h0000};
        for (int i = 0; i < NUM_CH; i++) begin
            s[8+i] = m_sticky[i];
            s[i]   = m_valid[i];
        end
        return s;
    endfunction

    // Measurement in ticks of an interval of 'cycles' clocks, clipped to the
    // counter width.
    function automatic int ticks_of(input int cycles, input int w, input int ps);
        int t;
        t = cycles / ps;
        return (t > (1 << w) - 1) ? (1 << w) - 1 : t;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_high[i] = 0; m_period[i] = 0; m_valid[i] = 0; m_sticky[i] = 0;
        end
    endtask

    task automatic model_wave(input int ch, input int h, input int p);
        m_high[ch]   = ticks_of(h, CNT_W, 1);
        m_period[ch] = ticks_of(p, CNT_W, 1);
        m_valid[ch]  = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0; ch0_pin = 1'b0; ch1_pin = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    task automatic set_pin(input int ch, input logic v);
        if (ch == 0) ch0_pin = v; else ch1_pin = v;
    endtask

    // n full periods starting with a rising edge, then one more rising edge
    // so the last period is captured; the pin is left high.
    task automatic drive_ch(input int ch, input int h, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            set_pin(ch, 1'b1);
            repeat (h) @(negedge clk);
            set_pin(ch, 1'b0);
            repeat (p - h) @(negedge clk);
        end
        set_pin(ch, 1'b1);
    endtask

    task automatic bus_read(input logic [4:0] a, input int which,
                            output logic [31:0] d, output logic v);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        case (which)
            1:       begin d = rdata_s; v = rdv_s; end
            2:       begin d = rdata_p; v = rdv_p; end
            default: begin d = rdata_m; v = rdv_m; end
        endcase
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d; logic v;
        do_reset();
        n_vec++;
        if (rdata_m !== 32'h0 || rdv_m !== 1'b0 || wait_m !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: got rdata=%h rdv=%b wait=%b want 0/0/0", rdata_m, rdv_m, wait_m);
        end
        @(negedge clk);
        addr = 5'd0; rd = 1'b1;
        #1;
        n_vec++;
        if (rdv_m !== 1'b0) begin n_err++; $display("FAIL rdv_early: got %b want 0", rdv_m); end
        @(negedge clk);
        rd = 1'b0;
        n_vec++;
        if (rdv_m !== 1'b1 || rdata_m !== 32'h0210_0000) begin
            n_err++; $display("FAIL status_reset: got rdv=%b %h want 1 02100000", rdv_m, rdata_m);
        end
        @(negedge clk);
        n_vec++;
        if (rdv_m !== 1'b0 || rdata_m !== 32'h0210_0000) begin
            n_err++; $display("FAIL rdv_pulse_hold: got rdv=%b %h want 0 02100000", rdv_m, rdata_m);
        end
        bus_read(5'd1, 0, d, v);
        n_vec++;
        if (d !== 32'h1 || v !== 1'b1) begin n_err++; $display("FAIL ctrl_reset: got %h want 00000001", d); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        addr = 5'd1; rd = 1'b1;
        @(negedge clk);
        addr = 5'd0;
        n_vec++;
        if (rdv_m !== 1'b1 || rdata_m !== 32'h1) begin
            n_err++; $display("FAIL b2b_first: got rdv=%b %h want 1 00000001", rdv_m, rdata_m);
        end
        @(negedge clk);
        rd = 1'b0;
        n_vec++;
        if (rdv_m !== 1'b1 || rdata_m !== exp_status()) begin
            n_err++; $display("FAIL b2b_second: got rdv=%b %h want 1 %h", rdv_m, rdata_m, exp_status());
        end
    endtask

    task automatic test_square();
        logic [31:0] d; logic v;
        do_reset();
        drive_ch(0, 30, 100, 3);
        model_wave(0, 30, 100);
        repeat (6) @(negedge clk);
        bus_read(5'd2, 0, d, v);
        n_vec++; if (d !== 32'(m_high[0])) begin n_err++; $display("FAIL square_high0: got %0d want %0d", d, m_high[0]); end
        bus_read(5'd3, 0, d, v);
        n_vec++; if (d !== 32'(m_period[0])) begin n_err++; $display("FAIL square_period0: got %0d want %0d", d, m_period[0]); end
        bus_read(5'd0, 0, d, v);
        n_vec++; if (d !== exp_status()) begin n_err++; $display("FAIL square_status: got %h want %h", d, exp_status()); end
        bus_read(5'd4, 0, d, v);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL square_high1: got %0d want 0", d); end
        bus_read(5'd5, 0, d, v);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL square_period1: got %0d want 0", d); end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic v;
        do_reset();
        drive_ch(1, 30, 100, 3);
        model_wave(1, 30, 100);
        repeat (980) @(negedge clk);
        bus_read(5'd0, 0, d, v);
        n_vec++; if (d !== exp_status()) begin n_err++; $display("FAIL before_timeout: got %h want %h", d, exp_status()); end
        repeat (30) @(negedge clk);
        m_valid[1] = 1'b0; m_sticky[1] = 1'b1; m_high[1] = 0; m_period[1] = 0;
        bus_read(5'd0, 0, d, v);
        n_vec++; if (d !== exp_status()) begin n_err++; $display("FAIL after_timeout: got %h want %h", d, exp_status()); end
        bus_read(5'd4, 0, d, v);
        n_vec++; if (d !== 32'(m_high[1])) begin n_err++; $display("FAIL timeout_high1: got %0d want %0d", d, m_high[1]); end
        bus_read(5'd5, 0, d, v);
        n_vec++; if (d !== 32'(m_period[1])) begin n_err++; $display("FAIL timeout_period1: got %0d want %0d", d, m_period[1]); end
        bus_write(5'd0, 32'h0000_0200);
        m_sticky[1] = 1'b0;
        bus_read(5'd0, 0, d, v);
        n_vec++; if (d !== exp_status()) begin n_err++; $display("FAIL sticky_w1c: got %h want %h", d, exp_status()); end
    endtask

    task automatic test_saturation();
        logic [31:0] d; logic v;
        int e;
        do_reset();
        drive_ch(0, 280, 300, 3);
        repeat (6) @(negedge clk);
        e = ticks_of(280, 8, 1);
        bus_read(5'd2, 1, d, v);
        n_vec++; if (d !== 32'(e)) begin n_err++; $display("FAIL sat_high: got %0d want %0d", d, e); end
        e = ticks_of(300, 8, 1);
        bus_read(5'd3, 1, d, v);
        n_vec++; if (d !== 32'(e)) begin n_err++; $display("FAIL sat_period: got %0d want %0d", d, e); end
        set_pin(0, 1'b0);
        repeat (50) @(negedge clk);
        drive_ch(0, 200, 400, 3);
        repeat (6) @(negedge clk);
        e = ticks_of(200, 16, 4);
        bus_read(5'd2, 2, d, v);
        n_vec++; if (int'(d) < e - 1 || int'(d) > e + 1) begin n_err++; $display("FAIL ps_high: got %0d want %0d+-1", d, e); end
        e = ticks_of(400, 16, 4);
        bus_read(5'd3, 2, d, v);
        n_vec++; if (int'(d) < e - 1 || int'(d) > e + 1) begin n_err++; $display("FAIL ps_period: got %0d want %0d+-1", d, e); end
    endtask

    task automatic test_snapshot();
        logic [31:0] d; logic v;
        do_reset();
        drive_ch(0, 30, 100, 3);
        repeat (6) @(negedge clk);
        bus_read(5'd2, 0, d, v);
        n_vec++; if (d !== 32'd30) begin n_err++; $display("FAIL snap_high_first: got %0d want 30", d); end
        set_pin(0, 1'b0);
        repeat (192) @(negedge clk);
        drive_ch(0, 60, 200, 2);
        repeat (6) @(negedge clk);
        bus_read(5'd3, 0, d, v);
        n_vec++; if (d !== 32'(SNAP_EXP)) begin n_err++; $display("FAIL snap_period: got %0d want %0d", d, SNAP_EXP); end
        bus_read(5'd2, 0, d, v);
        n_vec++; if (d !== 32'd60) begin n_err++; $display("FAIL snap_high_new: got %0d want 60", d); end
        bus_read(5'd3, 0, d, v);
        n_vec++; if (d !== 32'd200) begin n_err++; $display("FAIL snap_period_new: got %0d want 200", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic v;
        bus_read(5'd31, 0, d, v);
        n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL unmapped31: got %h want ffffffff", d); end
        bus_read(5'd6, 0, d, v);
        n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL unmapped6: got %h want ffffffff", d); end
        bus_write(5'd31, 32'h0);
        bus_read(5'd1, 0, d, v);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL unmapped_write_ctrl: got %h want 00000001", d); end
    endtask

    task automatic test_disable();
        logic [31:0] d; logic v;
        do_reset();
        drive_ch(0, 30, 100, 3);
        model_wave(0, 30, 100);
        repeat (6) @(negedge clk);
        // read and write of CTRL in the same cycle: read sees pre-write value
        @(negedge clk);
        addr = 5'd1; rd = 1'b1; wr = 1'b1; wdata = 32'h0;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        n_vec++; if (rdata_m !== 32'h1) begin n_err++; $display("FAIL rw_same_cycle: got %h want 00000001", rdata_m); end
        model_clear();
        bus_read(5'd1, 0, d, v);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ctrl_off: got %h want 0", d); end
        set_pin(0, 1'b0);
        repeat (70) @(negedge clk);
        drive_ch(0, 30, 100, 2);
        repeat (6) @(negedge clk);
        bus_read(5'd0, 0, d, v);
        n_vec++; if (d !== exp_status()) begin n_err++; $display("FAIL disabled_status: got %h want %h", d, exp_status()); end
        bus_read(5'd2, 0, d, v);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL disabled_high: got %0d want 0", d); end
        bus_read(5'd3, 0, d, v);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL disabled_period: got %0d want 0", d); end
        bus_write(5'd1, 32'h1);
        set_pin(0, 1'b0);
        repeat (70) @(negedge clk);
        drive_ch(0, 30, 100, 2);
        model_wave(0, 30, 100);
        repeat (6) @(negedge clk);
        bus_read(5'd2, 0, d, v);
        n_vec++; if (d !== 32'(m_high[0])) begin n_err++; $display("FAIL reenable_high: got %0d want %0d", d, m_high[0]); end
        bus_read(5'd3, 0, d, v);
        n_vec++; if (d !== 32'(m_period[0])) begin n_err++; $display("FAIL reenable_period: got %0d want %0d", d, m_period[0]); end
    endtask

    task automatic test_random();
        logic [31:0] d; logic v;
        int h0, p0, h1, p1;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            h0 = int'($urandom_range(5, 100)); p0 = h0 + int'($urandom_range(5, 100));
            h1 = int'($urandom_range(5, 100)); p1 = h1 + int'($urandom_range(5, 100));
            fork
                begin set_pin(0, 1'b0); repeat (10) @(negedge clk); drive_ch(0, h0, p0, 3); end
                begin set_pin(1, 1'b0); repeat (10) @(negedge clk); drive_ch(1, h1, p1, 3); end
            join
            model_wave(0, h0, p0);
            model_wave(1, h1, p1);
            repeat (6) @(negedge clk);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                bus_read(5'(2 + 2*ch), 0, d, v);
                n_vec++; if (d !== 32'(m_high[ch])) begin n_err++; $display("FAIL rand_high%0d it%0d: got %0d want %0d", ch, it, d, m_high[ch]); end
                bus_read(5'(3 + 2*ch), 0, d, v);
                n_vec++; if (d !== 32'(m_period[ch])) begin n_err++; $display("FAIL rand_period%0d it%0d: got %0d want %0d", ch, it, d, m_period[ch]); end
            end
            bus_read(5'd0, 0, d, v);
            n_vec++; if (d !== exp_status()) begin n_err++; $display("FAIL rand_status it%0d: got %h want %h", it, d, exp_status()); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic v;
        do_reset();
        drive_ch(0, 30, 100, 3);
        model_wave(0, 30, 100);
        repeat (6) @(negedge clk);
        bus_read(5'd0, 0, d, v);
        n_vec++; if (d !== exp_status()) begin n_err++; $display("FAIL pre_reset_status: got %h want %h", d, exp_status()); end
        repeat (10) @(negedge clk);
        addr = 5'd0; rd = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (rdata_m !== 32'h0 || rdv_m !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got rdata=%h rdv=%b want 0/0", rdata_m, rdv_m);
        end
        rd = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        bus_read(5'd1, 0, d, v);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL mid_reset_ctrl: got %h want 00000001", d); end
        bus_read(5'd0, 0, d, v);
        n_vec++; if (d !== exp_status()) begin n_err++; $display("FAIL mid_reset_status: got %h want %h", d, exp_status()); end
        bus_read(5'd2, 0, d, v);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_reset_high: got %0d want 0", d); end
        bus_read(5'd3, 0, d, v);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_reset_period: got %0d want 0", d); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_back_to_back();
        test_square();
        test_timeout();
        test_saturation();
        test_snapshot();
        test_unmapped();
        test_disable();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
